// File: rtl/pattern_scan_ctrl_pkg.sv
// pattern_scan_ctrl_pkg: shared state encoding, default widths and named patterns
package pattern_scan_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;
  localparam int DEF_WORD_W = 8;
  localparam int DEF_CNT_W = 4;
  localparam logic [2:0] PAT_010 = 3'b010;
  localparam logic [2:0] PAT_101 = 3'b101;
endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// pattern_scan_ctrl_if: requester, pattern and result handshake bundle
interface pattern_scan_ctrl_if
  import pattern_scan_ctrl_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int CNT_W = DEF_CNT_W
) ();
  logic req0_valid, req1_valid;
  logic [WORD_W-1:0] req0_data, req1_data;
  logic req0_ready, req1_ready;
  logic [2:0] pattern;
  logic res_valid;
  logic res_id;
  logic [CNT_W-1:0] res_count;
  logic res_ready;
  logic busy;
  modport master (
    output req0_valid, req1_valid, req0_data, req1_data, pattern, res_ready,
    input req0_ready, req1_ready, res_valid, res_id, res_count, busy
  );
  modport slave (
    input req0_valid, req1_valid, req0_data, req1_data, pattern, res_ready,
    output req0_ready, req1_ready, res_valid, res_id, res_count, busy
  );
endinterface

// File: rtl/pattern_scan_ctrl_detector.sv
// pattern_detector3: Mealy 3-bit pattern matcher that ignores windows reaching into a previous word
module pattern_detector3 (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic       data_bit,
  input  logic [2:0] pattern,
  output logic       match
);
  logic h1, h0;
  logic [1:0] seen;
  assign match = en && seen == 2'd2 && {h1, h0, data_bit} == pattern;
  // shift history and count bits of the current word, saturating at two
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      h1 <= 1'b0;
      h0 <= 1'b0;
      seen <= 2'd0;
    end else if (en) begin
      h1 <= h0;
      h0 <= data_bit;
      seen <= seen == 2'd2 ? seen : seen + 2'd1;
    end
  end
endmodule

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: two-requester arbiter that counts 3-bit pattern matches per scanned word
module pattern_scan_ctrl
  import pattern_scan_ctrl_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clock,
  input logic reset,
  pattern_scan_ctrl_if.slave bus
);
  localparam int BW = $clog2(WORD_W);
  state_t state;
  logic [WORD_W-1:0] sreg;
  logic [2:0] pat;
  logic [BW-1:0] bit_cnt;
  logic [CNT_W-1:0] count;
  logic id, last_grant, res_valid, busy;
  logic grant1, grant0, accept, match;
  assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
  assign grant0 = bus.req0_valid && !grant1;
  assign bus.req0_ready = state == IDLE && grant0;
  assign bus.req1_ready = state == IDLE && grant1;
  assign accept = bus.req0_ready || bus.req1_ready;
  assign bus.res_valid = res_valid;
  assign bus.res_id = id;
  assign bus.res_count = count;
  assign bus.busy = busy;
  pattern_detector3 u_det (
    .clock(clock),
    .reset(reset),
    .clear(accept),
    .en(state == SHIFT),
    .data_bit(sreg[WORD_W-1]),
    .pattern(pat),
    .match(match)
  );
  // accept a word, scan it MSB first, then hold the result until taken
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      sreg <= '0;
      pat <= '0;
      bit_cnt <= '0;
      count <= '0;
      id <= 1'b0;
      last_grant <= 1'b1;
      res_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sreg <= grant1 ? bus.req1_data : bus.req0_data;
          pat <= bus.pattern;
          id <= grant1;
          bit_cnt <= '0;
          count <= '0;
          busy <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          sreg <= sreg << 1;
          bit_cnt <= bit_cnt + BW'(1);
          count <= count + CNT_W'(match);
          if (bit_cnt == BW'(WORD_W - 1)) begin
            res_valid <= 1'b1;
            state <= REPORT;
          end
        end
        REPORT: if (bus.res_ready) begin
          res_valid <= 1'b0;
          busy <= 1'b0;
          last_grant <= id;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 8, meaning bits per scanned word (>=3).
REQ-002 SHALL have parameter CNT_W, default 4, meaning match-counter width (2^CNT_W-1 >= WORD_W-2).
REQ-003 SHALL have port clock  input  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports req0_valid, req1_valid  input  1 each  requester word offered.
REQ-006 SHALL have ports req0_data, req1_data  input  WORD_W each  word to scan, MSB first.
REQ-007 SHALL have ports req0_ready, req1_ready  output  1 each  word accepted this cycle when ANDed with valid.
REQ-008 SHALL have port pattern  input  3  target bit pattern, oldest bit in bit 2.
REQ-009 SHALL have port res_valid  output  1  result available.
REQ-010 SHALL have port res_id  output  1  requester index of result.
REQ-011 SHALL have port res_count  output  CNT_W  number of pattern matches in word.
REQ-012 SHALL have port res_ready  input  1  consumer takes result.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, REPORT.
REQ-015 In IDLE, SHALL grant one requester: if both valid, the one not equal to last_grant; if one valid, that one; assert only the granted ready, combinationally.
REQ-016 On accept (valid & ready), SHALL latch data into shift register, latch pattern, latch id, clear detector history and bit counter, clear count, go to SHIFT.
REQ-017 In SHIFT, SHALL feed shift-register MSB to detector each cycle, shift left, and leave SHIFT after exactly WORD_W cycles.
REQ-018 Detector SHALL be Mealy: match = {h1,h0,bit}==pattern AND at least 2 prior bits of the current word seen; count increments in the same cycle.
REQ-019 Overlapping matches SHALL count; matches SHALL never span two words.
REQ-020 Latency: accept in cycle T, bits in T+1..T+WORD_W, res_valid high from T+WORD_W+1.
REQ-021 In REPORT, res_valid, res_id, res_count SHALL hold stable until res_ready is sampled high; then go to IDLE and set last_grant = res_id.
REQ-022 Both ready outputs SHALL be 0 outside IDLE; pattern and req data changes outside the accept cycle SHALL have no effect.
REQ-023 res_valid SHALL be 0 outside REPORT; res_count SHALL not saturate or wrap (bound guaranteed by REQ-002).

Reset
REQ-024 reset SHALL take priority over all events, including an accept or res_ready in the same cycle.
REQ-025 After reset: state IDLE, last_grant=1 (req0 wins first tie), res_valid=0, res_id=0, res_count=0, busy=0, detector history cleared; any in-flight word is discarded without a result.

Structure
REQ-026 Shared package SHALL hold the state enum, default WORD_W/CNT_W, and constants PAT_010=3'b010, PAT_101=3'b101.
REQ-027 Detector SHALL be a sub-module pattern_detector3 (clock, reset, clear, en, bit, pattern -> match), holding two history bits and a seen-count.

Verification
REQ-028 req0 data 8'b0101_0100, pattern 010, accept at T -> res_valid at T+9, res_id 0, res_count 3.
REQ-029 req1 data 8'hAA, pattern 101 -> res_id 1, res_count 3; data 8'h00, pattern 010 -> res_count 0.
REQ-030 Both valid continuously, res_ready=1 -> grants alternate req0, req1, req0, req1 from reset.
REQ-031 res_ready held 0 for 5 cycles in REPORT -> res_valid/res_id/res_count stable, both ready 0, no new grant; released -> IDLE next cycle.
REQ-032 reset asserted in 4th SHIFT cycle -> next cycle IDLE, busy 0, res_valid 0, no result for that word; next accept goes to req0 on tie.
REQ-033 pattern changed from 010 to 101 mid-SHIFT on 8'b0101_0100 -> res_count still 3.
